audio_stream_arbiter: RTL
=========================

# audio_stream_arbiter

Two-source packet arbiter that shares the audio front end's single simple-interface consumer (framing/feature-extraction path) between two AXI-Stream audio sources, e.g. live microphone and test-pattern/playback DMA. Grants are round-robin at packet granularity (a grant holds until the `tlast` beat). Each accepted beat is re-registered onto a one-cycle valid-pulse simple interface tagged with its source ID. A stall watchdog reclaims the grant from a source that stops mid-packet.

## Interface
Parameters:
- `DATA_W`, 32, sample word width.
- `TIMEOUT`, 1024, stall watchdog limit in cycles; legal range 1..65535.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `en`  in  2  per-source enable; bit i gates requests from source i.
- `s0_tdata`  in  DATA_W  source 0 data.
- `s0_tvalid`  in  1  source 0 valid.
- `s0_tlast`  in  1  source 0 end of packet.
- `s0_tready`  out  1  source 0 ready.
- `s1_tdata`  in  DATA_W  source 1 data.
- `s1_tvalid`  in  1  source 1 valid.
- `s1_tlast`  in  1  source 1 end of packet.
- `s1_tready`  out  1  source 1 ready.
- `consumer_busy`  in  1  consumer cannot take a beat this cycle.
- `out_data`  out  DATA_W  registered beat data.
- `out_valid`  out  1  one-cycle pulse per beat.
- `out_last`  out  1  qualifies `out_valid`; copy of the `tlast` that was accepted.
- `out_src`  out  1  source ID of the current beat.
- `busy`  out  1  high when state is XFER.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- State machine has two states, IDLE and XFER. Registered `grant` (1 bit), `last_grant` (1 bit), watchdog counter width `$clog2(TIMEOUT+1)`.
- Request: `req[i] = si_tvalid && en[i]`.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one source requests, grant it.
  - If both request, grant `!last_grant`.
  - On any grant: go to XFER; clear the watchdog.
- XFER:
  - `si_tready = (grant==i) && !consumer_busy`, combinational. The non-granted source's `tready` is 0. Both `tready` are 0 in IDLE.
  - Accept = `tvalid && tready` of the granted source.
  - On accept:
    - Register `out_data <= tdata`, `out_last <= tlast`, `out_src <= grant`.
    - Next-cycle `out_valid = 1`.
    - Clear the watchdog.
  - Accept with `tlast=1`: set `last_grant <= grant` and go to IDLE.
  - No accept and `consumer_busy=0`: increment the watchdog. Busy cycles do not count.
  - Watchdog reaches TIMEOUT:
    - Go to IDLE.
    - Pulse `timeout_err` next cycle.
    - Set `last_grant <= grant`.
    - Emit no synthetic `out_last`; the consumer discards the partial frame on `timeout_err`.
- `en` change mid-packet: no effect on the current grant. It takes effect at the next IDLE arbitration.
- `out_valid` and `timeout_err` drop to 0 every cycle without a new event.
- `out_data`, `out_last` and `out_src` hold their values between pulses.

## Timing
- Reset (async, immediate): state IDLE, `grant=0`, `last_grant=1` (source 0 wins the first contention), watchdog 0. All outputs are 0: `s0_tready`, `s1_tready`, `out_*`, `busy`, `timeout_err`.
- Arbitration costs one cycle: request seen in IDLE at cycle t; `tready` high from t+1.
- Beat latency: accept at cycle t gives `out_valid` at t+1.
- Streaming throughput is 1 beat/cycle while the source is valid and `consumer_busy=0`.
- Inter-packet gap: `tlast` accepted at t, IDLE at t+1, next packet's first accept at t+2 at the earliest.
- `consumer_busy` high at cycle t forces `tready=0` in the same cycle; the source holds its data (AXI rule).
- Watchdog abort: the stall starts at cycle t (first non-busy cycle with no accept). The counter reaches TIMEOUT on the edge ending cycle t+TIMEOUT-1. `timeout_err` is 1 in cycle t+TIMEOUT; the state is IDLE in the same cycle.
- Simultaneous `tlast` accept and watchdog limit cannot occur, because an accept clears the watchdog; the `tlast` path takes precedence.
- Reset asserted mid-packet: abandon the packet; the source sees `tready=0` immediately.

## Test plan
- **Single packet, source 0.** `en=2'b11`; s0 sends 4 words 0x10..0x13 with `tlast` on 0x13. Required: `out_valid` pulses on 4 consecutive cycles, `out_src=0`, `out_last=1` only with 0x13, first `out_valid` 2 cycles after `s0_tvalid` rises.
- **Contention round-robin.** Both sources hold 3-word packets continuously. Required: grant order s0, s1, s0, s1; each packet delivered contiguously; 1-cycle gap between packets.
- **Backpressure.** Hold `consumer_busy=1` for 5 cycles mid-packet. Required: `tready=0` and no `out_valid` during those cycles, no `timeout_err` even with `TIMEOUT=3`, data order preserved.
- **Watchdog.** `TIMEOUT=8`; s1 sends 2 words, then drops `tvalid`. Required: `timeout_err` pulses exactly 8 cycles after the first idle cycle; state returns to IDLE; a pending s0 packet is granted next.
- **Enable masking.** `en=2'b01` with both sources valid: only s0 is served. Then clear `en[0]` mid-packet: the s0 packet completes, and no further grants are issued.
- **Async reset mid-packet.** Assert `reset` during the third beat. Required: all outputs are 0 immediately. After release, s0 wins the first contention.

Source files
------------

// File: rtl/audio_stream_if.sv
// audio_stream_if: two AXI-Stream sources in, one valid-pulse consumer stream out.
interface audio_stream_if #(parameter int DATA_W = 32);
  logic [1:0]        en;
  logic [DATA_W-1:0] s0_tdata;
  logic              s0_tvalid;
  logic              s0_tlast;
  logic              s0_tready;
  logic [DATA_W-1:0] s1_tdata;
  logic              s1_tvalid;
  logic              s1_tlast;
  logic              s1_tready;
  logic              consumer_busy;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_src;
  logic              busy;
  logic              timeout_err;
  modport master (
    output en, s0_tdata, s0_tvalid, s0_tlast, s1_tdata, s1_tvalid, s1_tlast, consumer_busy,
    input  s0_tready, s1_tready, out_data, out_valid, out_last, out_src, busy, timeout_err
  );
  modport slave (
    input  en, s0_tdata, s0_tvalid, s0_tlast, s1_tdata, s1_tvalid, s1_tlast, consumer_busy,
    output s0_tready, s1_tready, out_data, out_valid, out_last, out_src, busy, timeout_err
  );
endinterface

// File: rtl/audio_stream_arbiter.sv
// audio_stream_arbiter: packet round-robin between two audio sources with stall watchdog.
module audio_stream_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input logic          clk,
  input logic          reset,
  audio_stream_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CW-1:0]     wd_q, wd_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              out_src_q, out_src_d;
  logic              timeout_err_q, timeout_err_d;
  logic [1:0]        req;
  logic              g_valid, g_last, acc;
  logic [DATA_W-1:0] g_data;
  assign req           = {bus.s1_tvalid & bus.en[1], bus.s0_tvalid & bus.en[0]};
  assign g_valid       = grant_q ? bus.s1_tvalid : bus.s0_tvalid;
  assign g_last        = grant_q ? bus.s1_tlast : bus.s0_tlast;
  assign g_data        = grant_q ? bus.s1_tdata : bus.s0_tdata;
  assign acc           = (state_q == XFER) && g_valid && !bus.consumer_busy;
  assign bus.s0_tready = (state_q == XFER) && !grant_q && !bus.consumer_busy;
  assign bus.s1_tready = (state_q == XFER) && grant_q && !bus.consumer_busy;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_src     = out_src_q;
  assign bus.busy        = (state_q == XFER);
  assign bus.timeout_err = timeout_err_q;
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    wd_d          = wd_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_src_d     = out_src_q;
    out_valid_d   = 1'b0;
    timeout_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = XFER;
        grant_d = &req ? !last_grant_q : req[1];
        wd_d    = '0;
      end
    end else if (acc) begin
      out_data_d  = g_data;
      out_last_d  = g_last;
      out_src_d   = grant_q;
      out_valid_d = 1'b1;
      wd_d        = '0;
      if (g_last) begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
    end else if (!bus.consumer_busy) begin
      // Busy cycles are the consumer's fault, so only idle source cycles age the grant.
      wd_d = wd_q + 1'b1;
      if (wd_q == CW'(TIMEOUT - 1)) begin
        state_d       = IDLE;
        timeout_err_d = 1'b1;
        last_grant_d  = grant_q;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      wd_q          <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_src_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      wd_q          <= wd_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_src_q     <= out_src_d;
      timeout_err_q <= timeout_err_d;
    end
  end
endmodule
